// File: rtl/sdram_wb_arbiter_if.sv
// Wishbone bundle between the SoC masters, the arbiter and the SDRAM controller slave port.
// "slave" is the arbiter's view; "master" is the view of the masters plus the controller.
interface sdram_wb_arbiter_if #(
  parameter int unsigned NM    = 3,
  parameter int unsigned ADR_W = 27
);
  logic [NM*ADR_W-1:0] m_adr_i;
  logic [NM*32-1:0]    m_dat_i;
  logic [NM*4-1:0]     m_sel_i;
  logic [NM-1:0]       m_we_i;
  logic [NM-1:0]       m_cyc_i;
  logic [NM-1:0]       m_stb_i;
  logic [31:0]         m_dat_o;
  logic [NM-1:0]       m_ack_o;
  logic [NM-1:0]       m_err_o;
  logic [NM-1:0]       m_rty_o;
  logic [ADR_W-1:0]    s_adr_o;
  logic [31:0]         s_dat_o;
  logic [3:0]          s_sel_o;
  logic                s_we_o;
  logic                s_cyc_o;
  logic                s_stb_o;
  logic [31:0]         s_dat_i;
  logic                s_ack_i;
  logic                s_err_i;
  logic                s_rty_i;

  modport slave (
    input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    output m_dat_o, m_ack_o, m_err_o, m_rty_o,
    output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    input  s_dat_i, s_ack_i, s_err_i, s_rty_i
  );

  modport master (
    output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
    input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o,
    output s_dat_i, s_ack_i, s_err_i, s_rty_i
  );
endinterface

// File: rtl/sdram_wb_arbiter.sv
// Round-robin Wishbone arbiter for the SDRAM controller slave port, with a per-grant
// transfer quota that forces a streaming master to yield when others are waiting.
module sdram_wb_arbiter #(
  parameter int unsigned NM       = 3,
  parameter int unsigned ADR_W    = 27,
  parameter int unsigned MAX_XFER = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_wb_arbiter_if.slave    bus,
  output logic [NM-1:0]        gnt_o
);
  localparam int unsigned PW = (NM > 1) ? $clog2(NM) : 1;

  typedef enum logic {StIdle, StOwn} state_e;

  state_e         state_q, state_d;
  logic [NM-1:0]  gnt_q, gnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;

  logic [NM-1:0]  req;
  logic [PW-1:0]  g_idx, win_idx, idx_w;
  int unsigned    idx;
  logic           own, xfer, quota_hold;

  always_comb begin
    req   = bus.m_cyc_i & bus.m_stb_i;
    // ptr always sits one past the current owner, so the owner index is recovered from it
    g_idx = (ptr_q == '0) ? PW'(NM - 1) : ptr_q - 1'b1;

    // Walk from the farthest slot back to ptr so the nearest requester wins
    win_idx = '0;
    idx     = 0;
    idx_w   = '0;
    for (int i = NM - 1; i >= 0; i--) begin
      idx = int'(ptr_q) + i;
      if (idx >= NM) idx = idx - NM;
      idx_w = PW'(idx);
      if (req[idx_w]) win_idx = idx_w;
    end

    own        = (state_q == StOwn);
    xfer       = bus.s_ack_i | bus.s_err_i;
    quota_hold = own && (cnt_q >= 8'(MAX_XFER)) && (|(req & ~gnt_q));
  end

  // Datapath and response routing
  always_comb begin
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.s_sel_o = '0;
    bus.s_we_o  = 1'b0;
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    bus.m_rty_o = '0;
    bus.m_dat_o = bus.s_dat_i;
    gnt_o       = gnt_q;
    if (own) begin
      bus.s_adr_o        = bus.m_adr_i[g_idx*ADR_W +: ADR_W];
      bus.s_dat_o        = bus.m_dat_i[g_idx*32 +: 32];
      bus.s_sel_o        = bus.m_sel_i[g_idx*4 +: 4];
      bus.s_we_o         = bus.m_we_i[g_idx];
      bus.s_cyc_o        = bus.m_cyc_i[g_idx];
      bus.s_stb_o        = bus.m_stb_i[g_idx] & ~quota_hold;
      bus.m_ack_o[g_idx] = bus.s_ack_i;
      bus.m_err_o[g_idx] = bus.s_err_i;
      bus.m_rty_o[g_idx] = bus.s_rty_i;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          state_d        = StOwn;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          ptr_d          = (win_idx == PW'(NM - 1)) ? '0 : win_idx + 1'b1;
          cnt_d          = '0;
        end
      end
      StOwn: begin
        if (xfer && (cnt_q != 8'hff)) cnt_d = cnt_q + 8'd1;
        if (!bus.m_cyc_i[g_idx] || (quota_hold && !xfer)) begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed bench for sdram_wb_arbiter: grant latency, round-robin order, quota, retry, reset.
module tb_sdram_wb_arbiter;
  localparam int unsigned NM    = 3;
  localparam int unsigned ADR_W = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NM-1:0] gnt_o;
  int            total = 0;
  int            bad   = 0;

  sdram_wb_arbiter_if #(.NM(NM), .ADR_W(ADR_W)) bus ();

  sdram_wb_arbiter #(.NM(NM), .ADR_W(ADR_W), .MAX_XFER(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .gnt_o (gnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic v);
    bus.m_cyc_i[k] = v;
    bus.m_stb_i[k] = v;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.m_sel_i = '0;
    bus.m_we_i  = '0;
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    bus.s_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst         = 1'b0;
    bus.s_dat_i = 32'hdead_beef;
    #1;
    total++;
    if (bus.s_cyc_o !== 1'b0 || gnt_o !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle cyc=%b gnt=%b want cyc=0 gnt=000", bus.s_cyc_o, gnt_o);
    end
    total++;
    if (bus.m_dat_o !== 32'hdead_beef) begin
      bad++;
      $display("FAIL reset_dat got %h want deadbeef", bus.m_dat_o);
    end
    rst         = 1'b1;
    bus.s_ack_i = 1'b1;
    bus.s_err_i = 1'b1;
    bus.s_rty_i = 1'b1;
    #1;
    total++;
    if ({bus.m_ack_o, bus.m_err_o, bus.m_rty_o} !== 9'b0) begin
      bad++;
      $display("FAIL idle_resp got %b want 000000000", {bus.m_ack_o, bus.m_err_o, bus.m_rty_o});
    end
    bus.s_ack_i = 1'b0;
    bus.s_err_i = 1'b0;
    bus.s_rty_i = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_req(1, 1'b1);
    bus.m_adr_i[1*ADR_W +: ADR_W] = 27'h0000104;
    #1;
    total++;
    if (bus.s_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL single_latency cyc got %b want 0", bus.s_cyc_o);
    end
    tick();
    total++;
    if (gnt_o !== 3'b010 || bus.s_cyc_o !== 1'b1 || bus.s_adr_o !== 27'h0000104) begin
      bad++;
      $display("FAIL single_grant gnt=%b cyc=%b adr=%h want 010 1 0000104",
               gnt_o, bus.s_cyc_o, bus.s_adr_o);
    end
    tick();
    tick();
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 32'h1234_5678;
    #1;
    total++;
    if (bus.m_ack_o !== 3'b010 || bus.m_dat_o !== 32'h1234_5678) begin
      bad++;
      $display("FAIL single_ack ack=%b dat=%h want 010 12345678", bus.m_ack_o, bus.m_dat_o);
    end
    tick();
    bus.s_ack_i = 1'b0;
    set_req(1, 1'b0);
    #1;
    total++;
    if (bus.s_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL single_drop cyc got %b want 0", bus.s_cyc_o);
    end
    tick();
    total++;
    if (gnt_o !== 3'b000) begin
      bad++;
      $display("FAIL single_release gnt got %b want 000", gnt_o);
    end
  endtask

  task automatic test_round_robin();
    logic [NM-1:0] exp;
    do_reset();
    set_req(0, 1'b1);
    set_req(1, 1'b1);
    set_req(2, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      exp = 3'b001 << (i % 3);
      total++;
      if (gnt_o !== exp) begin
        bad++;
        $display("FAIL rr_grant[%0d] got %b want %b", i, gnt_o, exp);
      end
      bus.s_ack_i = 1'b1;
      #1;
      total++;
      if (bus.m_ack_o !== exp) begin
        bad++;
        $display("FAIL rr_ack[%0d] got %b want %b", i, bus.m_ack_o, exp);
      end
      tick();
      bus.s_ack_i = 1'b0;
      set_req(i % 3, 1'b0);
      tick();
      total++;
      if (gnt_o !== 3'b000) begin
        bad++;
        $display("FAIL rr_idle_gap[%0d] got %b want 000", i, gnt_o);
      end
      set_req(i % 3, 1'b1);
      tick();
    end
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
  endtask

  task automatic test_quota();
    int acks   = 0;
    int stb_ok = 0;
    do_reset();
    set_req(0, 1'b1);
    set_req(2, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.m_ack_o === 3'b001) acks++;
      if (bus.s_stb_o === 1'b1) stb_ok++;
      tick();
    end
    bus.s_ack_i = 1'b0;
    #1;
    total++;
    if (acks != 8 || stb_ok != 8) begin
      bad++;
      $display("FAIL quota_first acks=%0d stb=%0d want 8 8", acks, stb_ok);
    end
    total++;
    if (bus.s_stb_o !== 1'b0 || bus.s_cyc_o !== 1'b1 || gnt_o !== 3'b001) begin
      bad++;
      $display("FAIL quota_hold stb=%b cyc=%b gnt=%b want 0 1 001",
               bus.s_stb_o, bus.s_cyc_o, gnt_o);
    end
    tick();
    total++;
    if (gnt_o !== 3'b000 || bus.s_cyc_o !== 1'b0) begin
      bad++;
      $display("FAIL quota_release gnt=%b cyc=%b want 000 0", gnt_o, bus.s_cyc_o);
    end
    tick();
    bus.s_ack_i = 1'b1;
    #1;
    total++;
    if (gnt_o !== 3'b100 || bus.m_ack_o !== 3'b100) begin
      bad++;
      $display("FAIL quota_pass gnt=%b ack=%b want 100 100", gnt_o, bus.m_ack_o);
    end
    tick();
    bus.s_ack_i = 1'b0;
    set_req(2, 1'b0);
    tick();
    tick();
    total++;
    if (gnt_o !== 3'b001) begin
      bad++;
      $display("FAIL quota_resume gnt got %b want 001", gnt_o);
    end
    for (int i = 0; i < 12; i++) begin
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.m_ack_o === 3'b001) acks++;
      tick();
    end
    bus.s_ack_i = 1'b0;
    set_req(0, 1'b0);
    total++;
    if (acks != 20) begin
      bad++;
      $display("FAIL quota_total acks got %0d want 20", acks);
    end
    tick();
  endtask

  task automatic test_saturate();
    int acks = 0;
    int lost = 0;
    do_reset();
    set_req(0, 1'b1);
    tick();
    for (int i = 0; i < 260; i++) begin
      bus.s_ack_i = 1'b1;
      #1;
      if (bus.m_ack_o === 3'b001) acks++;
      if (gnt_o !== 3'b001) lost++;
      tick();
    end
    total++;
    if (acks != 260 || lost != 0) begin
      bad++;
      $display("FAIL sat_burst acks=%0d lost=%0d want 260 0", acks, lost);
    end
    bus.s_ack_i = 1'b0;
    set_req(2, 1'b1);
    #1;
    total++;
    if (bus.s_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL sat_no_wrap stb got %b want 0", bus.s_stb_o);
    end
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    tick();
  endtask

  task automatic test_retry();
    do_reset();
    set_req(1, 1'b1);
    tick();
    set_req(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.s_rty_i = 1'b1;
      #1;
      total++;
      if (bus.m_rty_o !== 3'b010 || bus.m_ack_o !== 3'b000) begin
        bad++;
        $display("FAIL rty_route[%0d] rty=%b ack=%b want 010 000", i, bus.m_rty_o, bus.m_ack_o);
      end
      tick();
    end
    bus.s_rty_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.s_ack_i = 1'b1;
      tick();
    end
    bus.s_ack_i = 1'b0;
    #1;
    total++;
    if (bus.s_stb_o !== 1'b1 || gnt_o !== 3'b010) begin
      bad++;
      $display("FAIL rty_not_counted stb=%b gnt=%b want 1 010", bus.s_stb_o, gnt_o);
    end
    bus.s_ack_i = 1'b1;
    tick();
    bus.s_ack_i = 1'b0;
    #1;
    total++;
    if (bus.s_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL rty_quota stb got %b want 0", bus.s_stb_o);
    end
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(1, 1'b1);
    tick();
    total++;
    if (bus.s_cyc_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_own cyc got %b want 1", bus.s_cyc_o);
    end
    rst = 1'b0;
    tick();
    bus.s_ack_i = 1'b1;
    #1;
    total++;
    if (bus.s_cyc_o !== 1'b0 || gnt_o !== 3'b000 || bus.m_ack_o !== 3'b000) begin
      bad++;
      $display("FAIL rmid_drop cyc=%b gnt=%b ack=%b want 0 000 000",
               bus.s_cyc_o, gnt_o, bus.m_ack_o);
    end
    bus.s_ack_i = 1'b0;
    rst         = 1'b1;
    set_req(0, 1'b1);
    tick();
    total++;
    if (gnt_o !== 3'b001) begin
      bad++;
      $display("FAIL rmid_ptr gnt got %b want 001", gnt_o);
    end
    bus.m_cyc_i = '0;
    bus.m_stb_i = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_quota();
    test_saturate();
    test_retry();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
